xcprt_uart: RTL and testbench

Character-printer peripheral selected by the address decoder's `cprt_sel` strobe in DEBUG builds. Accepts byte writes from the processor bus, buffers them in a small FIFO and serializes them as 8N1 UART frames on `tx`. A status word is exposed on the decoder's read path so firmware can poll for space before printing.

---
 rtl/xcprt_uart.sv | 116 +++++++++++
 tb/tb_xcprt_uart.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xcprt_uart.sv
// Debug character printer: bus-written bytes are queued in a small FIFO and
// shifted out as 8N1 UART frames; a status word lets firmware poll for space.
module xcprt_uart #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_AW = 4,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              tx
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         shift;
  logic [2:0]         bitcnt;
  logic [15:0]        baud;
  logic               ovf, full, busy, push_req, push, pop, ovf_clr, bit_end, tx_nx;
  logic               unused_bits;

  assign unused_bits = ^data_in[31:8];
  assign full     = (count == FULL_CNT);
  assign busy     = (state != IDLE) || (count != '0);
  assign push_req = sel && we && (addr == ADDR_W'(0));
  assign push     = push_req && !full;
  assign ovf_clr  = sel && we && (addr == ADDR_W'(1)) && data_in[0];
  assign bit_end  = (state != IDLE) && (baud == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (count != '0) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bitcnt == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tx_nx is registered into tx, so the line lags the state by one cycle.
  always_comb begin
    pop   = 1'b0;
    tx_nx = 1'b1;
    case (state)
      IDLE:  pop   = (count != '0);
      START: tx_nx = 1'b0;
      DATA:  tx_nx = shift[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx     <= 1'b1;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      tx <= tx_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shift  <= mem[rd_ptr];
      end else if (state == DATA && bit_end) begin
        shift <= {1'b0, shift[7:1]};
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a dropped push outranks a clear in the same cycle
      if (push_req && full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
      if (state == IDLE || bit_end) baud <= '0;
      else                          baud <= baud + 1'b1;
      if (state == START)                 bitcnt <= '0;
      else if (state == DATA && bit_end)  bitcnt <= bitcnt + 1'b1;
    end
  end

  always_comb begin
    data_out = '0;
    if (sel && !we && addr == ADDR_W'(1)) begin
      data_out[0]           = busy;
      data_out[1]           = full;
      data_out[2]           = ovf;
      data_out[FIFO_AW+8:8] = count;
    end
  end
endmodule

// File: tb/tb_xcprt_uart.sv
// Bench for xcprt_uart at CLK_DIV=4, FIFO_AW=2: a line monitor decodes frames
// from tx into a queue that is matched against the expected-byte scoreboard.
module tb_xcprt_uart;
  localparam int CD = 4;

  logic        clk, rst, sel, we, tx;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_stop[$];

  xcprt_uart #(.CLK_DIV(CD), .FIFO_AW(2), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // frame decoder: k counts negedges since the first low sample
  bit         mon_on = 1'b0;
  int         mk = 0, mstart = 0;
  logic [7:0] mb = '0;
  always @(negedge clk) begin
    if (rst) mon_on = 1'b0;
    else if (!mon_on) begin
      if (tx === 1'b0) begin mon_on = 1'b1; mk = 0; mstart = cyc; end
    end else begin
      mk++;
      if (mk >= 6 && mk <= 34 && (mk % CD) == 2) mb[(mk - 6) / CD] = tx;
      if (mk == 38) begin
        rx_q.push_back(mb); rx_t.push_back(mstart); rx_stop.push_back(tx);
      end
      if (mk == 39) mon_on = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic bus_read(input logic s, input logic w, input logic [1:0] a, output logic [31:0] v);
    sel = s; we = w; addr = a; #1;
    v = data_out;
    sel = 1'b0; we = 1'b0; addr = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1; tick(3); rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      n_cmp++;
      if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx_idle cyc=%0d got=%b want=1", i, tx); end
    end
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h want=00000000", v); end
  endtask

  task automatic test_single;
    logic [31:0] v;
    logic        want;
    logic [7:0]  b;
    int          n;
    b = 8'h55;
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    bus_write(2'd0, 32'h55);
    n = cyc;
    exp_q.push_back(b);
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      if (k >= 2 && k <= 5)       want = 1'b0;
      else if (k >= 6 && k <= 37) want = b[(k - 6) / CD];
      else                        want = 1'b1;
      n_cmp++;
      if (tx !== want) begin n_bad++; $display("FAIL single_wave k=%0d got=%b want=%b", k, tx, want); end
      if (k == 40) begin
        bus_read(1'b1, 1'b0, 2'd1, v);
        n_cmp++;
        if (v !== 32'h1) begin n_bad++; $display("FAIL single_busy_stop got=%h want=00000001", v); end
      end
      if (k == 41) begin
        bus_read(1'b1, 1'b0, 2'd1, v);
        n_cmp++;
        if (v !== 32'h0) begin n_bad++; $display("FAIL single_idle_after41 got=%h want=00000000", v); end
      end
    end
    n_cmp++;
    if (rx_q.size() != 1) begin n_bad++; $display("FAIL single_frames got=%0d want=1", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL single_byte got=%h want=%h", rx_q[0], exp_q[0]); end
      n_cmp++;
      if (rx_t[0] != n + 2) begin n_bad++; $display("FAIL single_latency got=%0d want=%0d", rx_t[0] - n, 2); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    int          first, w;
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    bus_write(2'd0, 32'h41);
    first = cyc;
    for (int i = 1; i < 6; i++) bus_write(2'd0, 32'h41 + i);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h41 + 8'(i));
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h407) begin n_bad++; $display("FAIL ovf_status got=%h want=00000407", v); end
    bus_write(2'd1, 32'h1);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h403) begin n_bad++; $display("FAIL ovf_clear got=%h want=00000403", v); end
    bus_write(2'd0, 32'h47);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h407) begin n_bad++; $display("FAIL ovf_reset_by_drop got=%h want=00000407", v); end
    bus_write(2'd1, 32'h0);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h407) begin n_bad++; $display("FAIL ovf_clear_bit0_zero got=%h want=00000407", v); end
    w = 0;
    while (rx_q.size() < 5 && w < 400) begin tick(1); w++; end
    tick(10);
    n_cmp++;
    if (rx_q.size() != 5) begin n_bad++; $display("FAIL ovf_frames got=%0d want=5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
      n_cmp++;
      if (rx_t[i] != first + 2 + 41 * i) begin n_bad++; $display("FAIL ovf_start%0d got=%0d want=%0d", i, rx_t[i] - first, 2 + 41 * i); end
      n_cmp++;
      if (rx_stop[i] !== 1'b1) begin n_bad++; $display("FAIL ovf_stop%0d got=%b want=1", i, rx_stop[i]); end
    end
    exp_q.delete();
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h4) begin n_bad++; $display("FAIL ovf_drained got=%h want=00000004", v); end
    bus_write(2'd1, 32'h1);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL ovf_final_clear got=%h want=00000000", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int          w;
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    bus_write(2'd0, 32'hA3);
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    tick(17);
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      n_cmp++;
      if (tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx k=%0d got=%b want=1", i, tx); end
      tick(1);
    end
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL rstmid_status got=%h want=00000000", v); end
    n_cmp++;
    if (rx_q.size() != 0) begin n_bad++; $display("FAIL rstmid_noframes got=%0d want=0", rx_q.size()); end
    bus_write(2'd0, 32'h3C);
    exp_q.push_back(8'h3C);
    w = 0;
    while (rx_q.size() < 1 && w < 100) begin tick(1); w++; end
    tick(60);
    n_cmp++;
    if (rx_q.size() != 1) begin n_bad++; $display("FAIL rstmid_after_frames got=%0d want=1", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_after_byte got=%h want=%h", rx_q[0], exp_q[0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_decode;
    logic [31:0] v;
    int          w;
    rx_q.delete(); rx_t.delete(); rx_stop.delete();
    bus_write(2'd3, 32'hFF);
    sel = 1'b0; we = 1'b1; addr = 2'd0; data_in = 32'h77;
    tick(1);
    we = 1'b0; data_in = '0;
    tick(30);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL dec_nowrite_status got=%h want=00000000", v); end
    n_cmp++;
    if (rx_q.size() != 0) begin n_bad++; $display("FAIL dec_nowrite_frames got=%0d want=0", rx_q.size()); end
    bus_write(2'd0, 32'h5A);
    exp_q.push_back(8'h5A);
    bus_read(1'b1, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h101) begin n_bad++; $display("FAIL dec_status_live got=%h want=00000101", v); end
    bus_read(1'b1, 1'b0, 2'd0, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL dec_read_off0 got=%h want=00000000", v); end
    bus_read(1'b1, 1'b0, 2'd3, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL dec_read_off3 got=%h want=00000000", v); end
    bus_read(1'b0, 1'b0, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL dec_unselected got=%h want=00000000", v); end
    bus_read(1'b1, 1'b1, 2'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL dec_write_cycle got=%h want=00000000", v); end
    w = 0;
    while (rx_q.size() < 1 && w < 100) begin tick(1); w++; end
    tick(5);
    n_cmp++;
    if (rx_q.size() != 1) begin n_bad++; $display("FAIL dec_frames got=%0d want=1", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL dec_byte got=%h want=%h", rx_q[0], exp_q[0]); end
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    test_reset();
    test_single();
    test_overflow();
    test_reset_mid();
    test_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
